masked_operand_sharer: RTL

//  Masking front-end for the 2-share masked AND gadget. It accepts unmasked operands X and Y

---
 rtl/masked_operand_sharer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/masked_operand_sharer.sv
// rtl/masked_operand_sharer.sv - two-share masking front-end for the masked AND gadget
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   seed_load, seed_val   reseed strobe and new LFSR state (zero seed halts sharing)
//   in_valid, in_ready    operand handshake; in_ready is combinational
//   x, y                  unmasked operands
//   out_valid             one-cycle pulse when x0/x1/y0/y1/r0..r2 carry a new operand pair
//   x0, x1, y0, y1        Boolean shares (x0^x1 == x, y0^y1 == y)
//   r0, r1, r2            refresh randomness for the gadget
//   z_valid               out_valid delayed by GADGET_LAT cycles
//   rnd_fault             randomness source is all-zero; no operands are accepted
module masked_operand_sharer #(
   parameter int unsigned       WIDTH      = 4,
   parameter int unsigned       LFSR_W     = 32,
   parameter logic [LFSR_W-1:0] LFSR_TAPS  = 32'h8020_0003,
   parameter logic [LFSR_W-1:0] SEED       = 32'hACE1_2B57,
   parameter int unsigned       WARMUP     = 4,
   parameter int unsigned       MIN_GAP    = 0,
   parameter int unsigned       GADGET_LAT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed_val,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  x,
   input  logic [WIDTH-1:0]  y,
   output logic              out_valid,
   output logic [WIDTH-1:0]  x0,
   output logic [WIDTH-1:0]  x1,
   output logic [WIDTH-1:0]  y0,
   output logic [WIDTH-1:0]  y1,
   output logic [WIDTH-1:0]  r0,
   output logic [WIDTH-1:0]  r1,
   output logic [WIDTH-1:0]  r2,
   output logic              z_valid,
   output logic              rnd_fault
);

   localparam int unsigned K      = 5 * WIDTH;
   localparam int unsigned WARM_W = (WARMUP  > 0) ? $clog2(WARMUP + 1)  : 1;
   localparam int unsigned GAP_W  = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

   typedef enum logic [1:0] {ST_WARM, ST_RUN, ST_FAULT} state_t;

   state_t              state_q, state_d;
   logic [WARM_W-1:0]   warm_q, warm_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
   logic                ov_q, ov_d;
   logic [WIDTH-1:0]    x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
   logic [WIDTH-1:0]    r0_q, r0_d, r1_q, r1_d, r2_q, r2_d;
   logic [GADGET_LAT-1:0] zpipe_q;
   logic                accept;

   // K Galois steps per advance so every slice of R is fresh for each operand pair.
   function automatic logic [LFSR_W-1:0] lfsr_advance(input logic [LFSR_W-1:0] s);
      logic [LFSR_W-1:0] v;
      v = s;
      for (int i = 0; i < int'(K); i++) begin
         v = v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
      end
      return v;
   endfunction

   always_comb begin
      state_d  = state_q;
      warm_d   = warm_q;
      gap_d    = gap_q;
      lfsr_d   = lfsr_q;
      ov_d     = 1'b0;
      x0_d     = x0_q;
      x1_d     = x1_q;
      y0_d     = y0_q;
      y1_d     = y1_q;
      r0_d     = r0_q;
      r1_d     = r1_q;
      r2_d     = r2_q;
      in_ready = 1'b0;
      accept   = 1'b0;

      case (state_q)
         ST_WARM: begin
            lfsr_d = lfsr_advance(lfsr_q);
            // Leave on the cycle the counter reaches zero so WARMUP cycles are spent here.
            if (warm_q <= WARM_W'(1)) begin
               warm_d  = '0;
               state_d = ST_RUN;
            end else begin
               warm_d = warm_q - WARM_W'(1);
            end
         end
         ST_RUN: begin
            in_ready = !seed_load && (gap_q == '0);
            accept   = in_valid && in_ready;
            if (accept) begin
               // Operands are only ever stored already XORed with a mask slice.
               lfsr_d = lfsr_advance(lfsr_q);
               gap_d  = GAP_W'(MIN_GAP);
               ov_d   = 1'b1;
               x0_d   = x ^ lfsr_q[WIDTH-1:0];
               x1_d   = lfsr_q[WIDTH-1:0];
               y0_d   = y ^ lfsr_q[2*WIDTH-1:WIDTH];
               y1_d   = lfsr_q[2*WIDTH-1:WIDTH];
               r0_d   = lfsr_q[3*WIDTH-1:2*WIDTH];
               r1_d   = lfsr_q[4*WIDTH-1:3*WIDTH];
               r2_d   = lfsr_q[5*WIDTH-1:4*WIDTH];
            end else if (gap_q != '0) begin
               gap_d = gap_q - GAP_W'(1);
            end
         end
         default: begin
         end
      endcase

      // Reseed overrides everything; in_ready already excludes an accept this cycle.
      if (seed_load) begin
         lfsr_d = seed_val;
         gap_d  = '0;
         warm_d = WARM_W'(WARMUP);
         if (seed_val == '0) begin
            state_d = ST_FAULT;
         end else begin
            state_d = ST_WARM;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_WARM;
         warm_q  <= WARM_W'(WARMUP);
         gap_q   <= '0;
         lfsr_q  <= SEED;
         ov_q    <= 1'b0;
         x0_q    <= '0;
         x1_q    <= '0;
         y0_q    <= '0;
         y1_q    <= '0;
         r0_q    <= '0;
         r1_q    <= '0;
         r2_q    <= '0;
         zpipe_q <= '0;
      end else begin
         state_q <= state_d;
         warm_q  <= warm_d;
         gap_q   <= gap_d;
         lfsr_q  <= lfsr_d;
         ov_q    <= ov_d;
         x0_q    <= x0_d;
         x1_q    <= x1_d;
         y0_q    <= y0_d;
         y1_q    <= y1_d;
         r0_q    <= r0_d;
         r1_q    <= r1_d;
         r2_q    <= r2_d;
         // Keeps shifting in every state so in-flight gadget results drain.
         zpipe_q[0] <= ov_q;
         for (int i = 1; i < int'(GADGET_LAT); i++) begin
            zpipe_q[i] <= zpipe_q[i-1];
         end
      end
   end

   assign out_valid = ov_q;
   assign x0        = x0_q;
   assign x1        = x1_q;
   assign y0        = y0_q;
   assign y1        = y1_q;
   assign r0        = r0_q;
   assign r1        = r1_q;
   assign r2        = r2_q;
   assign z_valid   = zpipe_q[GADGET_LAT-1];
   assign rnd_fault = (state_q == ST_FAULT);

endmodule
